dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a CPU load/store unit and dmem_responder.
// The master modport is the CPU side; the slave modport is the memory side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic [2:0]  memop;
  logic        mem_wen;
  logic [31:0] memdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] mem_data;
  logic        resp_err;

  modport master (
    output req_valid, mem_addr, memop, mem_wen, memdata, resp_ready,
    input  req_ready, resp_valid, mem_data, resp_err
  );

  modport slave (
    input  req_valid, mem_addr, memop, mem_wen, memdata, resp_ready,
    output req_ready, resp_valid, mem_data, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for a RISC-V style load/store port.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned H/W accesses instead of force-aligning them.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic           accept;
  logic           we;
  logic [31:0]    offset;
  logic [31:0]    word_off;
  logic [IdxW-1:0] idx;
  logic           op_ok;
  logic           in_range;
  logic           misalign;
  logic           req_err;
  logic [1:0]     lane;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic [31:0]    rd_word;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    ld_data;

  // Address decode, legality and lane selection for the request on the bus.
  always_comb begin
    offset   = bus.mem_addr - BASE_ADDR;
    word_off = offset >> 2;
    in_range = (bus.mem_addr >= BASE_ADDR) && (word_off < DEPTH_WORDS);
    idx      = word_off[IdxW-1:0];

    op_ok = 1'b0;
    case (bus.memop)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_ok = 1'b1;
      default:                                op_ok = 1'b0;
    endcase

    misalign = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    case (bus.memop[1:0])
      2'b01:   misalign = bus.mem_addr[0];
      2'b10:   misalign = |bus.mem_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif

    // Without the error feature, low bits are simply masked to natural alignment.
    case (bus.memop[1:0])
      2'b00:   lane = bus.mem_addr[1:0];
      2'b01:   lane = {bus.mem_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase

    req_err = !op_ok || !in_range || misalign;
  end

  always_comb begin
    rd_word = mem_q[idx];
    rd_byte = rd_word[8*lane +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    ld_data = '0;
    case (bus.memop)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = '0;
    endcase

    case (bus.memop[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.memdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.memdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.memdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    resp_err_d = resp_err_q;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          mem_data_d = (req_err || bus.mem_wen) ? 32'h0 : ld_data;
          resp_err_d = req_err;
          if (LATENCY > 1) begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = StResp;
            cnt_d   = 4'h0;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A request seen while reset is still asserted must not touch the array.
  assign we = accept && bus.mem_wen && !req_err && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'h0;
      mem_data_q <= 32'h0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.mem_data   = mem_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed load/store sequence, error cases,
// back-pressure hold and reset during a pending transaction.
module tb_dmem_responder;
  localparam int unsigned Lat  = 2;
  localparam logic [31:0] Base = 32'h8000_0000;

  localparam logic [2:0] OpB  = 3'b000;
  localparam logic [2:0] OpH  = 3'b001;
  localparam logic [2:0] OpW  = 3'b010;
  localparam logic [2:0] OpBu = 3'b100;
  localparam logic [2:0] OpHu = 3'b101;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (Base),
    .LATENCY    (Lat)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, expect the response Lat cycles later, optionally stall it.
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [2:0] op,
                        input logic wen, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
    resp_t       exp;
    int          cyc;
    logic [31:0] held;
    check_eq({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.mem_addr   = addr;
    bus.memop      = op;
    bus.mem_wen    = wen;
    bus.memdata    = wdata;
    bus.resp_ready = (hold == 0);
    sb_q.push_back({exp_data, exp_err});
    @(posedge clk); #1;
    // Scramble request fields while busy; they must have no effect.
    bus.req_valid = 1'b0;
    bus.mem_addr  = $urandom;
    bus.memop     = 3'($urandom);
    bus.mem_wen   = 1'($urandom);
    bus.memdata   = $urandom;
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'(Lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check_eq({tag, "_data"}, bus.mem_data, exp.data);
    check_eq({tag, "_err"}, 32'(bus.resp_err), 32'(exp.err));
    held = bus.mem_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_v"}, 32'(bus.resp_valid), 32'd1);
      check_eq({tag, "_hold_d"}, bus.mem_data, held);
      check_eq({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_done"}, 32'(bus.resp_valid), 32'd0);
  endtask

  // Accept a request, then assert reset while it is still waiting.
  task automatic reset_in_wait(input string tag, input logic [31:0] addr, input logic [2:0] op,
                               input logic wen, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.memop     = op;
    bus.mem_wen   = wen;
    bus.memdata   = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq({tag, "_rst_v"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, "_rst_d"}, bus.mem_data, 32'h0);
    check_eq({tag, "_rst_e"}, 32'(bus.resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_post_v"}, 32'(bus.resp_valid), 32'd0);
      check_eq({tag, "_post_rdy"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  logic [31:0] exp_mis_data;
  logic        exp_mis_err;
  logic [31:0] exp_word4;

  initial begin
`ifdef DMEM_MISALIGN_ERR_EN
    exp_mis_data = 32'h0;
    exp_mis_err  = 1'b1;
    exp_word4    = 32'hBEEF_3344;
`else
    exp_mis_data = 32'h1234_5678;
    exp_mis_err  = 1'b0;
    exp_word4    = 32'hBEEF_7777;
`endif
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.mem_addr   = '0;
    bus.memop      = '0;
    bus.mem_wen    = 1'b0;
    bus.memdata    = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_rdy", 32'(bus.req_ready), 32'd1);
    check_eq("reset_v", 32'(bus.resp_valid), 32'd0);
    check_eq("reset_d", bus.mem_data, 32'h0);
    check_eq("reset_e", 32'(bus.resp_err), 32'd0);

    do_req("sw10", 32'h8000_0010, OpW, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    do_req("lw10", 32'h8000_0010, OpW, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("sb11", 32'h8000_0011, OpB, 1'b1, 32'h0000_0080, 32'h0, 1'b0, 0);
    do_req("lb11", 32'h8000_0011, OpB, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
    do_req("lbu11", 32'h8000_0011, OpBu, 1'b0, 32'h0, 32'h0000_0080, 1'b0, 0);
    do_req("lw10b", 32'h8000_0010, OpW, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 0);
    do_req("lh12", 32'h8000_0012, OpH, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0, 0);
    do_req("lhu12", 32'h8000_0012, OpHu, 1'b0, 32'h0, 32'h0000_DEAD, 1'b0, 0);

    do_req("sw00", 32'h8000_0000, OpW, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 0);
    do_req("sw04", 32'h8000_0004, OpW, 1'b1, 32'h1122_3344, 32'h0, 1'b0, 0);
    do_req("sh06", 32'h8000_0006, OpH, 1'b1, 32'hFFFF_BEEF, 32'h0, 1'b0, 0);
    do_req("lhu04", 32'h8000_0004, OpHu, 1'b0, 32'h0, 32'h0000_3344, 1'b0, 0);
    do_req("lh06", 32'h8000_0006, OpH, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);

    do_req("lw02", 32'h8000_0002, OpW, 1'b0, 32'h0, exp_mis_data, exp_mis_err, 0);
    do_req("sh05", 32'h8000_0005, OpH, 1'b1, 32'h0000_7777, 32'h0, exp_mis_err, 0);
    do_req("lw04", 32'h8000_0004, OpW, 1'b0, 32'h0, exp_word4, 1'b0, 0);

    do_req("lw_low", 32'h7FFF_FFFC, OpW, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    do_req("sw_low", 32'h7FFF_FFFC, OpW, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("sw_high", 32'h8000_1000, OpW, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("lw_high", 32'h8000_1000, OpW, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    do_req("op011", 32'h8000_0000, 3'b011, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("op110", 32'h8000_0000, 3'b110, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    do_req("op111", 32'h8000_0000, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("lw00", 32'h8000_0000, OpW, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0);
    do_req("lw_last", 32'h8000_0FFC, OpW, 1'b1, 32'h0BAD_CAFE, 32'h0, 1'b0, 0);
    do_req("lw_lastr", 32'h8000_0FFC, OpW, 1'b0, 32'h0, 32'h0BAD_CAFE, 1'b0, 0);

    do_req("hold", 32'h8000_0010, OpW, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 5);

    reset_in_wait("rst_ld", 32'h8000_0010, OpW, 1'b0, 32'h0);
    reset_in_wait("rst_st", 32'h8000_0020, OpW, 1'b1, 32'hCAFE_F00D);
    do_req("lw20", 32'h8000_0020, OpW, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    do_req("lw10c", 32'h8000_0010, OpW, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
